// File: rtl/seq_scan_pkg.sv
// Shared types for the bounded serial pattern-scan controller.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic plen_legal(input int plen, input int pat_w);
        return (plen >= 1) && (plen <= pat_w);
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Command, serial stream and status bundle between host/source and seq_scan_ctrl.
interface seq_scan_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    localparam int PL_W = $clog2(PAT_W) + 1;

    logic             start;
    logic [PAT_W-1:0] cfg_pattern;
    logic [PL_W-1:0]  cfg_plen;
    logic [LEN_W-1:0] cfg_nbits;
    logic             din;
    logic             din_valid;
    logic             din_ready;
    logic             busy;
    logic             hit;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] hit_count;
    logic             overflow;

    modport master (
        output start, cfg_pattern, cfg_plen, cfg_nbits, din, din_valid,
        input  din_ready, busy, hit, done, err, hit_count, overflow
    );

    modport slave (
        input  start, cfg_pattern, cfg_plen, cfg_nbits, din, din_valid,
        output din_ready, busy, hit, done, err, hit_count, overflow
    );

endinterface

// File: rtl/seq_match.sv
// Overlapping Mealy matcher: shift history with fill depth, length-masked compare.
module seq_match #(
    parameter int PAT_W = 4,
    parameter int PL_W  = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PL_W-1:0]  plen,
    output logic             match
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] mask;
    logic [PAT_W:0]   one_at_len;
    logic [PL_W-1:0]  depth;
    logic [PL_W-1:0]  depth_nxt;

    // Match looks at the history as it will be after this bit shifts in.
    always_comb begin
        hist_nxt   = PAT_W'({hist, din});
        depth_nxt  = (int'(depth) >= PAT_W) ? depth : depth + PL_W'(1);
        one_at_len = (PAT_W+1)'(1) << plen;
        mask       = PAT_W'(one_at_len - (PAT_W+1)'(1));
        match      = (depth_nxt >= plen) && ((hist_nxt & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist  <= '0;
            depth <= '0;
        end else if (clear) begin
            hist  <= '0;
            depth <= '0;
        end else if (shift_en) begin
            hist  <= hist_nxt;
            depth <= depth_nxt;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Session controller: captures a pattern/budget, feeds exactly that many bits
// through the matcher, counts hits and signals completion.
//
//   state  | meaning
//   S_IDLE | waiting for start; config sampled here only
//   S_RUN  | din_ready high, consuming bits until budget exhausted
//   S_DONE | one-cycle done pulse, hit_count final
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_scan_ctrl_if.slave bus
);

    localparam int PL_W = $clog2(PAT_W) + 1;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [PL_W-1:0]  plen_q;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] hit_count_q;
    logic             overflow_q;
    logic             busy_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic             cfg_ok;
    logic             xfer;
    logic             match;
    logic             hit_w;
    logic             clear_hist;

    assign cfg_ok     = plen_legal(int'(bus.cfg_plen), PAT_W);
    // ready_q is only ever high in S_RUN, so xfer and hit are confined to RUN.
    assign xfer       = ready_q & bus.din_valid;
    assign hit_w      = xfer & match;
    assign clear_hist = (state == S_IDLE) & bus.start & cfg_ok;

    seq_match #(
        .PAT_W (PAT_W),
        .PL_W  (PL_W)
    ) u_match (
        .clk      (clk),
        .rst      (rst),
        .shift_en (xfer),
        .clear    (clear_hist),
        .din      (bus.din),
        .pattern  (pat_q),
        .plen     (plen_q),
        .match    (match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            plen_q      <= '0;
            remaining   <= '0;
            hit_count_q <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (!cfg_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            pat_q       <= bus.cfg_pattern;
                            plen_q      <= bus.cfg_plen;
                            remaining   <= bus.cfg_nbits;
                            hit_count_q <= '0;
                            overflow_q  <= 1'b0;
                            if (bus.cfg_nbits == '0) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state   <= S_RUN;
                                busy_q  <= 1'b1;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        remaining <= remaining - LEN_W'(1);
                        if (hit_w) begin
                            if (hit_count_q == '1)
                                overflow_q <= 1'b1;
                            else
                                hit_count_q <= hit_count_q + CNT_W'(1);
                        end
                        if (remaining == LEN_W'(1)) begin
                            state   <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.hit       = hit_w;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.hit_count = hit_count_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed sessions plus random streams
// compared against a bit-history reference model.
module tb_seq_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   hits;

    seq_scan_ctrl_if #(.PAT_W(4), .LEN_W(8), .CNT_W(8)) a ();
    seq_scan_ctrl_if #(.PAT_W(4), .LEN_W(8), .CNT_W(2)) b ();

    seq_scan_ctrl #(.PAT_W(4), .LEN_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    seq_scan_ctrl #(.PAT_W(4), .LEN_W(8), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hit if the most recent plen session bits, oldest first, spell pat[plen-1:0].
    function automatic logic model_hit(input logic hist[$], input logic [3:0] pat, input int plen);
        int n;
        n = hist.size();
        if (n < plen) return 1'b0;
        for (int j = 0; j < plen; j++)
            if (hist[n-1-j] !== pat[j]) return 1'b0;
        return 1'b1;
    endfunction

    // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid
    task automatic session(input logic [3:0] pat, input int plen, input int nbits,
                           input int mode, input logic [255:0] stream,
                           input bit poke_start, output int n_hits);
        logic q[$];
        logic tmp[$];
        int   cnt;
        int   cyc;
        int   exp_cnt;
        logic v;
        logic eh;
        cnt = 0; cyc = 0; exp_cnt = 0;
        @(negedge clk);
        a.start       = 1'b1;
        a.cfg_pattern = pat;
        a.cfg_plen    = 3'(plen);
        a.cfg_nbits   = 8'(nbits);
        @(posedge clk); #1;
        a.start = 1'b0;
        if (nbits != 0) begin
            check("busy_after_start", 32'(a.busy), 32'd1);
            check("ready_after_start", 32'(a.din_ready), 32'd1);
            check("count_cleared", 32'(a.hit_count), 32'd0);
            while (cnt < nbits && cyc < 4 * nbits + 50) begin
                @(negedge clk);
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                a.din_valid = v;
                a.din       = stream[cnt];
                if (poke_start && cyc == 2) begin
                    a.start       = 1'b1;
                    a.cfg_pattern = 4'($urandom);
                    a.cfg_plen    = 3'($urandom_range(0, 7));
                    a.cfg_nbits   = 8'($urandom_range(0, 3));
                end
                tmp = q;
                tmp.push_back(a.din);
                eh = v && model_hit(tmp, pat, plen);
                #1;
                check("hit", 32'(a.hit), 32'(eh));
                check("ready_run", 32'(a.din_ready), 32'd1);
                @(posedge clk); #1;
                a.start = 1'b0;
                if (v) begin
                    q.push_back(a.din);
                    cnt++;
                    if (eh && exp_cnt < 255) exp_cnt++;
                end
                cyc++;
                check("err_in_run", 32'(a.err), 32'd0);
                check("count_run", 32'(a.hit_count), 32'(exp_cnt));
                if (cnt < nbits) check("busy_run", 32'(a.busy), 32'd1);
            end
            check("session_len", 32'(cnt), 32'(nbits));
            a.din_valid = 1'b0;
        end
        check("done_pulse", 32'(a.done), 32'd1);
        check("busy_done", 32'(a.busy), 32'd0);
        check("ready_done", 32'(a.din_ready), 32'd0);
        check("count_final", 32'(a.hit_count), 32'(exp_cnt));
        check("ovf_final", 32'(a.overflow), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(a.done), 32'd0);
        check("idle_busy", 32'(a.busy), 32'd0);
        check("count_hold", 32'(a.hit_count), 32'(exp_cnt));
        n_hits = exp_cnt;
    endtask

    initial begin
        rst = 1'b0;
        a.start = 1'b0; a.cfg_pattern = '0; a.cfg_plen = '0; a.cfg_nbits = '0;
        a.din = 1'b0; a.din_valid = 1'b0;
        b.start = 1'b0; b.cfg_pattern = '0; b.cfg_plen = '0; b.cfg_nbits = '0;
        b.din = 1'b0; b.din_valid = 1'b0;
        #12;
        check("rst_busy", 32'(a.busy), 32'd0);
        check("rst_ready", 32'(a.din_ready), 32'd0);
        check("rst_done", 32'(a.done), 32'd0);
        check("rst_err", 32'(a.err), 32'd0);
        check("rst_count", 32'(a.hit_count), 32'd0);
        check("rst_ovf", 32'(a.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1011 over 1,0,1,1,0,1,1: overlapping hits on bits 4 and 7
        session(4'b1011, 4, 7, 0, 256'(7'b1101101), 1'b0, hits);
        check("t1_hits", 32'(hits), 32'd2);

        // illegal plen: err pulse only, previous count untouched
        @(negedge clk);
        a.start = 1'b1; a.cfg_plen = 3'd0; a.cfg_nbits = 8'd5;
        @(posedge clk); #1;
        a.start = 1'b0;
        check("err_plen0", 32'(a.err), 32'd1);
        check("err_busy", 32'(a.busy), 32'd0);
        check("err_count_kept", 32'(a.hit_count), 32'd2);
        @(posedge clk); #1;
        check("err_one_cycle", 32'(a.err), 32'd0);
        @(negedge clk);
        a.start = 1'b1; a.cfg_plen = 3'd5;
        @(posedge clk); #1;
        a.start = 1'b0;
        check("err_plen5", 32'(a.err), 32'd1);
        check("err5_ready", 32'(a.din_ready), 32'd0);

        // valid in IDLE: no hit, count unchanged
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a.din_valid = 1'b1; a.din = 1'b1;
            #1;
            check("idle_hit", 32'(a.hit), 32'd0);
            @(posedge clk); #1;
            check("idle_count", 32'(a.hit_count), 32'd2);
        end
        a.din_valid = 1'b0;

        // 111 over all ones with valid gaps: hits on bits 3,4,5
        session(4'b0111, 3, 5, 1, '1, 1'b0, hits);
        check("t2_hits", 32'(hits), 32'd3);

        // zero-bit session
        session(4'b0101, 2, 0, 0, '0, 1'b0, hits);

        // start during RUN with new config is ignored
        session(4'b1011, 4, 7, 0, 256'(7'b1101101), 1'b1, hits);
        check("t5_hits", 32'(hits), 32'd2);

        // counter saturation on the CNT_W=2 instance
        @(negedge clk);
        b.start = 1'b1; b.cfg_pattern = 4'b0001; b.cfg_plen = 3'd1; b.cfg_nbits = 8'd6;
        @(posedge clk); #1;
        b.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b.din_valid = 1'b1; b.din = 1'b1;
            #1;
            check("sat_hit", 32'(b.hit), 32'd1);
            @(posedge clk); #1;
            check("sat_count", 32'(b.hit_count), 32'((i + 1 > 3) ? 3 : i + 1));
            check("sat_ovf", 32'(b.overflow), 32'((i + 1 >= 4) ? 1 : 0));
        end
        b.din_valid = 1'b0;
        check("sat_done", 32'(b.done), 32'd1);
        @(posedge clk); #1;
        check("sat_ovf_hold", 32'(b.overflow), 32'd1);
        check("sat_count_hold", 32'(b.hit_count), 32'd3);

        // reset mid-session after 3 of 8 bits
        @(negedge clk);
        a.start = 1'b1; a.cfg_pattern = 4'b0001; a.cfg_plen = 3'd1; a.cfg_nbits = 8'd8;
        @(posedge clk); #1;
        a.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a.din_valid = 1'b1; a.din = 1'b1;
            @(posedge clk); #1;
        end
        check("pre_rst_count", 32'(a.hit_count), 32'd3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(a.busy), 32'd0);
        check("arst_ready", 32'(a.din_ready), 32'd0);
        check("arst_hit", 32'(a.hit), 32'd0);
        check("arst_count", 32'(a.hit_count), 32'd0);
        check("arst_ovf", 32'(b.overflow), 32'd0);
        @(posedge clk); #1;
        check("arst_no_done", 32'(a.done), 32'd0);
        @(negedge clk);
        rst = 1'b1; a.din_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_done", 32'(a.done), 32'd0);
        check("post_rst_busy", 32'(a.busy), 32'd0);
        session(4'b1011, 4, 7, 0, 256'(7'b1110110), 1'b0, hits);
        check("post_rst_hits", 32'(hits), 32'd1);

        // random sessions
        for (int s = 0; s < 6; s++) begin
            session(4'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 40)), 2,
                    {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom}, 1'b0, hits);
        end
        session(4'($urandom), int'($urandom_range(1, 4)), 200, 0,
                {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom}, 1'b0, hits);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
